// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 encodings, FSM state type and access checking for
//            the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int c_WORD_SIZE = 32;

    localparam logic [2:0] c_MEM_B  = 3'b000;
    localparam logic [2:0] c_MEM_H  = 3'b001;
    localparam logic [2:0] c_MEM_W  = 3'b010;
    localparam logic [2:0] c_MEM_BU = 3'b100;
    localparam logic [2:0] c_MEM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } lsu_state_t;

    // Legal funct3 for the direction, and natural alignment for the size.
    function automatic logic f_access_ok(
        input logic       is_store,
        input logic [2:0] op,
        input logic [1:0] addr_lo
    );
        logic ok;
        case (op)
            c_MEM_B, c_MEM_BU: ok = 1'b1;
            c_MEM_H, c_MEM_HU: ok = ~addr_lo[0];
            c_MEM_W:           ok = (addr_lo == 2'b00);
            default:           ok = 1'b0;
        endcase
        if (is_store && op[2]) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Combinational load lane extraction with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_mem_op,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_mem_op)
            c_MEM_B:  o_data = {{24{w_byte[7]}}, w_byte};
            c_MEM_BU: o_data = {24'd0, w_byte};
            c_MEM_H:  o_data = {{16{w_half[15]}}, w_half};
            c_MEM_HU: o_data = {16'd0, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory stage: req/gnt/rvalid data-memory master with byte
//            enables, load alignment and one writeback beat per instruction.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_SIZE  = c_WORD_SIZE,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  alu_out,
    input  logic [WORD_SIZE-1:0]  store_data,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            mem_op,
    input  logic [4:0]            rd_in,
    input  logic                  reg_write_in,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [4:0]            wb_rd,
    output logic [WORD_SIZE-1:0]  wb_data,
    output logic                  exc_misaligned
);

    lsu_state_t r_state;
    lsu_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_be;
    logic [WORD_SIZE-1:0]  r_mem_wdata;
    logic [WORD_SIZE-1:0]  r_wb_data;
    logic [4:0]            r_rd;
    logic [2:0]            r_op;
    logic [1:0]            r_addr_lo;
    logic                  r_is_store;
    logic                  r_wb_we;
    logic                  r_exc;

    logic                  w_accept;
    logic                  w_is_mem;
    logic                  w_is_st;
    logic                  w_ok;
    logic                  w_capture;
    logic [3:0]            w_st_be;
    logic [WORD_SIZE-1:0]  w_st_wdata;
    logic [WORD_SIZE-1:0]  w_load_data;

    // A simultaneous is_load/is_store is treated as a load.
    assign w_is_mem = is_load | is_store;
    assign w_is_st  = is_store & ~is_load;
    assign w_ok     = f_access_ok(w_is_st, mem_op, alu_out[1:0]);
    assign w_accept = in_valid & (r_state == ST_IDLE);

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = store_data;
        case (mem_op[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << alu_out[1:0];
                w_st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << alu_out[1:0];
                w_st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_is_mem && w_ok) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = (r_is_store || mem_rvalid) ? ST_DONE : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (mem_rvalid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Zero-wait memory returns data in the same cycle as the grant.
    assign w_capture = ~r_is_store &
                       (((r_state == ST_REQ) & mem_gnt & mem_rvalid) |
                        ((r_state == ST_WAIT_RD) & mem_rvalid));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_wb_data   <= '0;
            r_rd        <= '0;
            r_op        <= '0;
            r_addr_lo   <= '0;
            r_is_store  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_exc       <= 1'b0;
        end else if (w_accept) begin
            r_mem_addr  <= {alu_out[ADDR_WIDTH-1:2], 2'b00};
            r_mem_be    <= w_is_st ? w_st_be : 4'b1111;
            r_mem_wdata <= w_is_st ? w_st_wdata : '0;
            r_wb_data   <= alu_out;
            r_rd        <= rd_in;
            r_op        <= mem_op;
            r_addr_lo   <= alu_out[1:0];
            r_is_store  <= w_is_st;
            r_wb_we     <= w_is_mem ? (w_ok & ~w_is_st) : reg_write_in;
            r_exc       <= w_is_mem & ~w_ok;
        end else if (w_capture) begin
            r_wb_data   <= w_load_data;
        end
    end

    lsu_load_align u_load_align (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_addr_lo),
        .i_mem_op  (r_op),
        .o_data    (w_load_data)
    );

    assign in_ready       = (r_state == ST_IDLE);
    assign mem_req        = (r_state == ST_REQ);
    assign mem_we         = mem_req & r_is_store;
    assign mem_addr       = r_mem_addr;
    assign mem_be         = r_mem_be;
    assign mem_wdata      = r_mem_wdata;
    assign wb_valid       = (r_state == ST_DONE);
    assign wb_we          = wb_valid & r_wb_we;
    assign wb_rd          = r_rd;
    assign wb_data        = r_wb_data;
    assign exc_misaligned = wb_valid & r_exc;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_op;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misaligned;

    int total = 0;
    int bad   = 0;

    logic [31:0] obs_wb_data;
    logic [31:0] obs_mem_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_exc;
    logic        obs_we;
    int          obs_req;
    int          obs_lat;

    load_store_unit #(.WORD_SIZE(32), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_out        (alu_out),
        .store_data     (store_data),
        .is_load        (is_load),
        .is_store       (is_store),
        .mem_op         (mem_op),
        .rd_in          (rd_in),
        .reg_write_in   (reg_write_in),
        .mem_req        (mem_req),
        .mem_gnt        (mem_gnt),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic [2:0] op);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'd0:    return (b > 127) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h > 32767) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Issues one instruction, plays the memory side, checks every cycle until writeback.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input logic rw,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        logic        is_mem, legal, exp_exc, go_mem, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_data;
        int          exp_lat, req_n, wait_n;
        bit          got, granted;

        is_mem  = ld | st;
        legal   = ld ? (op != 3'd3 && op != 3'd6 && op != 3'd7) : (op <= 3'd2);
        exp_exc = is_mem && (!legal || (addr % (32'd1 << op[1:0])) != 0);
        go_mem  = is_mem && !exp_exc;
        exp_be  = !st ? 4'hF : (op == 3'd0) ? (4'b0001 << addr[1:0]) :
                  (op == 3'd1) ? (4'b0011 << addr[1:0]) : 4'hF;
        exp_wd  = (op == 3'd0) ? sdata[7:0] * 32'h0101_0101 :
                  (op == 3'd1) ? sdata[15:0] * 32'h0001_0001 : sdata;
        exp_data = ld ? model_load(rdata, addr[1:0], op) : addr;
        exp_we   = !is_mem ? rw : (go_mem && ld);
        exp_lat  = !go_mem ? 0 : (st || rv_dly == 0) ? gnt_dly + 1 : gnt_dly + 1 + rv_dly;

        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL ready_idle got=%b exp=1", in_ready);
        end
        in_valid = 1'b1; alu_out = addr; store_data = sdata; is_load = ld; is_store = st;
        mem_op = op; rd_in = rd; reg_write_in = rw;
        @(negedge clk);
        in_valid = 1'b0; alu_out = $urandom; store_data = $urandom; is_load = $urandom;
        is_store = $urandom; mem_op = $urandom; rd_in = $urandom; reg_write_in = $urandom;

        got = 0; granted = 0; req_n = 0; wait_n = 0;
        obs_req = 0; obs_mem_addr = '0; obs_be = '0; obs_wdata = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (c > 0) @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL ready_busy cyc=%0d got=%b exp=0", c, in_ready);
            end
            if (wb_valid === 1'b1) begin
                got = 1; obs_lat = c; obs_wb_data = wb_data; obs_exc = exc_misaligned;
                obs_we = wb_we; obs_req = req_n;
                total++;
                if (c != exp_lat) begin
                    bad++; $display("FAIL latency got=%0d exp=%0d", c, exp_lat);
                end
                total++;
                if (wb_we !== exp_we) begin
                    bad++; $display("FAIL wb_we got=%b exp=%b", wb_we, exp_we);
                end
                total++;
                if (wb_rd !== rd) begin
                    bad++; $display("FAIL wb_rd got=%0d exp=%0d", wb_rd, rd);
                end
                total++;
                if (exc_misaligned !== exp_exc) begin
                    bad++; $display("FAIL exc got=%b exp=%b", exc_misaligned, exp_exc);
                end
                if (!exp_exc && !st) begin
                    total++;
                    if (wb_data !== exp_data) begin
                        bad++; $display("FAIL wb_data got=%h exp=%h", wb_data, exp_data);
                    end
                end
                total++;
                if (req_n != (go_mem ? gnt_dly + 1 : 0)) begin
                    bad++; $display("FAIL req_cycles got=%0d exp=%0d", req_n,
                                    go_mem ? gnt_dly + 1 : 0);
                end
            end else if (mem_req === 1'b1) begin
                obs_mem_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
                total++;
                if (!go_mem || mem_addr !== {addr[31:2], 2'b00} || mem_we !== st ||
                    mem_be !== exp_be || (st && mem_wdata !== exp_wd)) begin
                    bad++;
                    $display("FAIL mem_req go=%b addr=%h/%h we=%b/%b be=%b/%b wd=%h/%h",
                             go_mem, mem_addr, {addr[31:2], 2'b00}, mem_we, st,
                             mem_be, exp_be, mem_wdata, exp_wd);
                end
                if (req_n == gnt_dly) begin
                    mem_gnt = 1'b1; granted = 1;
                    if (ld && rv_dly == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = rdata;
                    end
                end else begin
                    mem_rvalid = $urandom_range(0, 1);
                end
                req_n++;
            end else if (granted && ld) begin
                wait_n++;
                if (wait_n == rv_dly) begin
                    mem_rvalid = 1'b1; mem_rdata = rdata;
                end
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL wb_timeout got=none exp=wb_valid");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_req, mem_we, wb_valid, wb_we, exc_misaligned} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                            {mem_req, mem_we, wb_valid, wb_we, exc_misaligned});
        end
        total++;
        if ({mem_addr, mem_be, mem_wdata, wb_data, wb_rd} !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0",
                            mem_addr, mem_be, mem_wdata, wb_data, wb_rd);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
        reset = 1'b1;
    endtask

    task automatic test_passthrough();
        run_op(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0);
        total++;
        if (obs_wb_data !== 32'h0000_1234 || obs_req != 0 || obs_lat != 0) begin
            bad++; $display("FAIL passthrough got=%h req=%0d lat=%0d exp=00001234 req=0 lat=0",
                            obs_wb_data, obs_req, obs_lat);
        end
    endtask

    task automatic test_load_byte();
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'h0, 5'd7, 1'b0, 0, 1, 32'h80FF_1122);
        total++;
        if (obs_wb_data !== 32'hFFFF_FF80 || obs_mem_addr !== 32'h0000_0100) begin
            bad++; $display("FAIL lb_sign got=%h addr=%h exp=ffffff80 addr=00000100",
                            obs_wb_data, obs_mem_addr);
        end
        run_op(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'h0, 5'd8, 1'b0, 0, 1, 32'h80FF_1122);
        total++;
        if (obs_wb_data !== 32'h0000_0080) begin
            bad++; $display("FAIL lbu_zero got=%h exp=00000080", obs_wb_data);
        end
    endtask

    task automatic test_store_half();
        run_op(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1'b1, 3, 0, 32'h0);
        total++;
        if (obs_be !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_req != 4 || obs_we !== 1'b0) begin
            bad++; $display("FAIL sh_lanes be=%b wd=%h req=%0d we=%b exp be=1100 wd=beefbeef req=4 we=0",
                            obs_be, obs_wdata, obs_req, obs_we);
        end
    endtask

    task automatic test_misaligned();
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0, 5'd4, 1'b1, 0, 1, 32'h0);
        total++;
        if (obs_exc !== 1'b1 || obs_we !== 1'b0 || obs_req != 0) begin
            bad++; $display("FAIL lw_misaligned exc=%b we=%b req=%0d exp exc=1 we=0 req=0",
                            obs_exc, obs_we, obs_req);
        end
        run_op(1'b0, 1'b1, 3'd4, 32'h0000_0004, 32'h1, 5'd6, 1'b0, 0, 0, 32'h0);
        total++;
        if (obs_exc !== 1'b1) begin
            bad++; $display("FAIL store_illegal exc=%b exp=1", obs_exc);
        end
    endtask

    task automatic test_zero_wait();
        run_op(1'b1, 1'b0, 3'd5, 32'h0000_0002, 32'h0, 5'd10, 1'b0, 0, 0, 32'h9876_5432);
        total++;
        if (obs_wb_data !== 32'h0000_9876 || obs_lat != 1) begin
            bad++; $display("FAIL zero_wait got=%h lat=%0d exp=00009876 lat=1", obs_wb_data, obs_lat);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; mem_op = 3'd2;
        alu_out = 32'h0000_0100; rd_in = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++; $display("FAIL rst_in_req mem_req=%b exp=0", mem_req);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        total++;
        if (mem_req !== 1'b0 || in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL wait_rd_state req=%b rdy=%b wb=%b exp 0/0/0",
                            mem_req, in_ready, wb_valid);
        end
        reset = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_wait req=%b wb=%b rdy=%b exp 0/0/1",
                            mem_req, wb_valid, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            total++;
            if (wb_valid !== 1'b0) begin
                bad++; $display("FAIL late_rvalid cyc=%0d wb_valid=%b exp=0", i, wb_valid);
            end
        end
    endtask

    task automatic test_random();
        logic        ld, st;
        logic [31:0] addr;
        int          kind;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            ld   = (kind == 1);
            st   = (kind == 2);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_op(ld, st, 3'($urandom_range(0, 7)), addr, $urandom, 5'($urandom),
                   1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; alu_out = '0; store_data = '0; is_load = 1'b0;
        is_store = 1'b0; mem_op = '0; rd_in = '0; reg_write_in = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_zero_wait();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
